// File: rtl/fifo_ctrl_pkg.sv
// Shared state encodings, default sizes and a width helper for the shared-FIFO controller.
package fifo_ctrl_pkg;

  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above rrPtr, wrapping modulo NREQ.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   winner
);

  logic          found;
  logic [TW-1:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = TW'((int'(rr_ptr) + i) % NREQ);
      if (enable && !found && req[idx]) begin
        found    = 1'b1;
        winner   = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one byte FIFO between NREQ producers and one consumer, tracking the writer tag of
// every entry, draining on flush and flagging disagreement between occupancy and FIFO flags.
module fifo_share_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TW    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  fifo_push,
  output logic [DW-1:0]         fifo_din,
  output logic                  fifo_pop,
  input  logic [DW-1:0]         fifo_dout,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DW-1:0]         rd_data,
  output logic [TW-1:0]         rd_tag,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [clog2(DEPTH):0] occupancy,
  output logic                  sync_err
);

  localparam int AW = clog2(DEPTH);
  localparam int OW = AW + 1;

  state_e        state_q, state_d;
  logic [TW-1:0] rrPtr_q, rrPtr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [TW-1:0] tagMem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW-1:0] wrPtrNext, rdPtrNext;
  logic          rdValid_q;
  logic [DW-1:0] rdData_q;
  logic [TW-1:0] rdTag_q;
  logic          syncErr_q;

  logic          inRun, inDrain;
  logic          pop, pushEn, pushOk, popOk, desync;
  logic [TW-1:0] winner;

  assign inRun   = (state_q == ST_RUN);
  assign inDrain = (state_q == ST_DRAIN);

  // Pop outranks push so the FIFO never sees both strobes in one cycle.
  assign pop    = (inRun & rd_req & ~fifo_empty) | (inDrain & ~fifo_empty);
  assign pushEn = inRun & ~fifo_full & ~pop;

  rr_arbiter #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rrPtr_q),
    .enable (pushEn),
    .gnt    (gnt),
    .winner (winner)
  );

  assign fifo_push = |gnt;
  assign fifo_pop  = pop;
  assign fifo_din  = fifo_push ? req_data[int'(winner)*DW +: DW] : '0;

  assign pushOk    = fifo_push && (occ_q != OW'(DEPTH));
  assign popOk     = pop && (occ_q != '0);
  assign wrPtrNext = (wrPtr_q == AW'(DEPTH-1)) ? '0 : wrPtr_q + 1'b1;
  assign rdPtrNext = (rdPtr_q == AW'(DEPTH-1)) ? '0 : rdPtr_q + 1'b1;
  assign desync    = ((occ_q == '0) != fifo_empty) | ((occ_q == OW'(DEPTH)) != fifo_full);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if ((occ_q == '0) && !pop) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    occ_d   = occ_q;
    rrPtr_d = rrPtr_q;
    if (pushOk) occ_d = occ_q + 1'b1;
    else if (popOk) occ_d = occ_q - 1'b1;
    if (fifo_push) rrPtr_d = TW'((int'(winner) + 1) % NREQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      rrPtr_q   <= '0;
      occ_q     <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdTag_q   <= '0;
      syncErr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tagMem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      occ_q     <= occ_d;
      syncErr_q <= syncErr_q | desync;
      if (pushOk) begin
        tagMem_q[wrPtr_q] <= winner;
        wrPtr_q           <= wrPtrNext;
      end
      if (popOk) rdPtr_q <= rdPtrNext;
      // Drain pops are discarded, so only RUN pops reach the consumer.
      rdValid_q <= pop & inRun;
      if (pop && inRun) begin
        rdData_q <= fifo_dout;
        rdTag_q  <= tagMem_q[rdPtr_q];
      end
    end
  end

  assign rd_valid   = rdValid_q;
  assign rd_data    = rdData_q;
  assign rd_tag     = rdTag_q;
  assign flush_busy = inDrain;
  assign flush_done = (state_q == ST_DONE);
  assign occupancy  = occ_q;
  assign sync_err   = syncErr_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Testbench for fifo_share_ctrl: behavioural 4-entry FIFO, grant/read scoreboards and directed checks.
module tb_fifo_share_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_push;
  logic [7:0]  fifo_din;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        rd_req;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [1:0]  rd_tag;
  logic        flush;
  logic        flush_busy;
  logic        flush_done;
  logic [2:0]  occupancy;
  logic        sync_err;
  logic        forceEmpty;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed { logic [3:0] gnt; logic [7:0] data; } gntExp_t;
  typedef struct packed { logic [7:0] data; logic [1:0] tag; } rdExp_t;
  gntExp_t expGntQ[$];
  rdExp_t  expRdQ[$];

  fifo_share_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_push  (fifo_push),
    .fifo_din   (fifo_din),
    .fifo_pop   (fifo_pop),
    .fifo_dout  (fifo_dout),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_tag     (rd_tag),
    .flush      (flush),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .occupancy  (occupancy),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO sharing the controller's reset; forceEmpty lets the bench fake a desync.
  logic [7:0] fMem [4];
  logic [1:0] fHead, fTail;
  logic [2:0] fCnt;
  logic       fPushOk, fPopOk;
  assign fPushOk    = fifo_push && (fCnt != 3'd4);
  assign fPopOk     = fifo_pop && (fCnt != 3'd0);
  assign fifo_empty = (fCnt == 3'd0) || forceEmpty;
  assign fifo_full  = (fCnt == 3'd4);
  assign fifo_dout  = fMem[fHead];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fHead <= '0;
      fTail <= '0;
      fCnt  <= '0;
      for (int i = 0; i < 4; i++) fMem[i] <= '0;
    end else begin
      if (fPushOk) begin
        fMem[fTail] <= fifo_din;
        fTail       <= fTail + 2'd1;
      end
      if (fPopOk) fHead <= fHead + 2'd1;
      fCnt <= fCnt + {2'b0, fPushOk} - {2'b0, fPopOk};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic rd, input logic fl);
    req      = r;
    req_data = d;
    rd_req   = rd;
    flush    = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitNeg();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nextCycle();
  endtask

  // Monitor: every push and every read result is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_push) begin
        if (expGntQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL push_unexpected: got gnt=0x%0h din=0x%0h, expected no push", gnt, fifo_din);
        end else begin
          gntExp_t e;
          e = expGntQ.pop_front();
          checkOutput("sb_gnt", {28'b0, gnt}, {28'b0, e.gnt});
          checkOutput("sb_fifo_din", {24'b0, fifo_din}, {24'b0, e.data});
        end
      end
      if (rd_valid) begin
        if (expRdQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL read_unexpected: got data=0x%0h tag=%0d, expected no rd_valid", rd_data, rd_tag);
        end else begin
          rdExp_t r;
          r = expRdQ.pop_front();
          checkOutput("sb_rd_data", {24'b0, rd_data}, {24'b0, r.data});
          checkOutput("sb_rd_tag", {30'b0, rd_tag}, {30'b0, r.tag});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t1Data [4];
    t1Data = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1;
    forceEmpty = 1'b0;
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    waitNeg();
    checkOutput("rst_outputs", {gnt, fifo_push, fifo_pop, rd_valid, flush_busy, flush_done, sync_err}, 32'h0);
    checkOutput("rst_rd_data", {22'b0, rd_data, rd_tag}, 32'h0);
    checkOutput("rst_occupancy", {29'b0, occupancy}, 32'h0);
    reset = 1'b0;
    nextCycle();

    $display("[TB] single producer fill");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0001, {24'h0, t1Data[k]}, 1'b0, 1'b0);
      expGntQ.push_back({4'b0001, t1Data[k]});
      nextCycle();
    end
    applyStimulus(4'b0001, 32'h55, 1'b0, 1'b0);
    waitNeg();
    checkOutput("full_gnt", {28'b0, gnt}, 32'h0);
    checkOutput("full_occupancy", {29'b0, occupancy}, 32'd4);
    checkOutput("full_sync_err", {31'b0, sync_err}, 32'h0);
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) expRdQ.push_back({t1Data[k], 2'd0});
    repeat (4) nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    waitNeg();
    checkOutput("t1_empty_occupancy", {29'b0, occupancy}, 32'd0);

    $display("[TB] round-robin fairness");
    doReset();
    applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) expGntQ.push_back({4'(1 << i), 8'hA0 + 8'(i)});
    repeat (4) nextCycle();
    waitNeg();
    checkOutput("rr_full_gnt", {28'b0, gnt}, 32'h0);
    nextCycle();
    applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b1, 1'b0);
    expRdQ.push_back({8'hA0, 2'd0});
    waitNeg();
    checkOutput("rr_pop_blocks_gnt", {28'b0, gnt, 3'b0, fifo_pop}, 32'h1);
    nextCycle();
    applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'hA0});
    waitNeg();
    checkOutput("rr_wrap_gnt", {28'b0, gnt}, 32'h1);
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b1, 1'b0);
    expRdQ.push_back({8'hA1, 2'd1});
    expRdQ.push_back({8'hA2, 2'd2});
    expRdQ.push_back({8'hA3, 2'd3});
    expRdQ.push_back({8'hA0, 2'd0});
    repeat (4) nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] read path with tags");
    doReset();
    applyStimulus(4'b0100, 32'h00A50000, 1'b0, 1'b0);
    expGntQ.push_back({4'b0100, 8'hA5});
    nextCycle();
    applyStimulus(4'b0010, 32'h00005A00, 1'b0, 1'b0);
    expGntQ.push_back({4'b0010, 8'h5A});
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b1, 1'b0);
    expRdQ.push_back({8'hA5, 2'd2});
    expRdQ.push_back({8'h5A, 2'd1});
    repeat (2) nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    waitNeg();
    checkOutput("rd_hold_valid", {31'b0, rd_valid}, 32'h0);
    checkOutput("rd_hold_data_tag", {22'b0, rd_data, rd_tag}, {22'b0, 8'h5A, 2'd1});
    nextCycle();

    $display("[TB] pop priority");
    applyStimulus(4'b0001, 32'h01, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h01});
    nextCycle();
    applyStimulus(4'b0001, 32'h02, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h02});
    nextCycle();
    applyStimulus(4'b0010, 32'h00007700, 1'b1, 1'b0);
    expRdQ.push_back({8'h01, 2'd0});
    expRdQ.push_back({8'h02, 2'd0});
    waitNeg();
    checkOutput("prio_occupancy", {29'b0, occupancy}, 32'd2);
    checkOutput("prio_cycle0", {28'b0, gnt, 3'b0, fifo_pop}, 32'h1);
    nextCycle();
    waitNeg();
    checkOutput("prio_cycle1", {28'b0, gnt, 3'b0, fifo_pop}, 32'h1);
    nextCycle();
    expGntQ.push_back({4'b0010, 8'h77});
    waitNeg();
    checkOutput("prio_push_after_empty", {28'b0, gnt, 3'b0, fifo_pop}, 32'h20);
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b1, 1'b0);
    expRdQ.push_back({8'h77, 2'd1});
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] flush drain");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, {8'h00, 8'h31 + 8'(k), 16'h0}, 1'b0, 1'b0);
      expGntQ.push_back({4'b0100, 8'h31 + 8'(k)});
      nextCycle();
    end
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b1);
    waitNeg();
    checkOutput("flush_start_occ", {29'b0, occupancy}, 32'd3);
    checkOutput("flush_start_busy", {31'b0, flush_busy}, 32'h0);
    nextCycle();
    applyStimulus(4'b1111, 32'hEEEEEEEE, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitNeg();
      checkOutput("drain_pop_cycle", {24'b0, gnt, flush_busy, fifo_pop, rd_valid, flush_done}, 32'h0C);
      nextCycle();
    end
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    waitNeg();
    checkOutput("drain_last_cycle", {28'b0, flush_busy, fifo_pop, flush_done, 1'b0}, 32'h8);
    nextCycle();
    waitNeg();
    checkOutput("flush_done_pulse", {28'b0, flush_done, flush_busy, 2'b0}, 32'h8);
    checkOutput("flush_done_occ", {29'b0, occupancy}, 32'd0);
    nextCycle();
    waitNeg();
    checkOutput("flush_back_to_run", {30'b0, flush_done, flush_busy}, 32'h0);
    nextCycle();

    $display("[TB] reset during drain");
    applyStimulus(4'b0001, 32'h41, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h41});
    nextCycle();
    applyStimulus(4'b0001, 32'h42, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h42});
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    waitNeg();
    checkOutput("pre_reset_busy", {31'b0, flush_busy}, 32'h1);
    #1 reset = 1'b1;
    waitNeg();
    checkOutput("midrst_flags", {gnt, fifo_push, fifo_pop, rd_valid, flush_busy, flush_done, sync_err}, 32'h0);
    checkOutput("midrst_rd", {22'b0, rd_data, rd_tag}, 32'h0);
    checkOutput("midrst_occ", {29'b0, occupancy}, 32'h0);
    reset = 1'b0;
    nextCycle();

    $display("[TB] desync detection");
    applyStimulus(4'b0001, 32'h51, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h51});
    nextCycle();
    applyStimulus(4'b0001, 32'h52, 1'b0, 1'b0);
    expGntQ.push_back({4'b0001, 8'h52});
    nextCycle();
    applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
    waitNeg();
    checkOutput("desync_pre_occ", {29'b0, occupancy}, 32'd2);
    checkOutput("desync_pre_err", {31'b0, sync_err}, 32'h0);
    nextCycle();
    forceEmpty = 1'b1;
    nextCycle();
    forceEmpty = 1'b0;
    waitNeg();
    checkOutput("desync_err_set", {31'b0, sync_err}, 32'h1);
    nextCycle();
    nextCycle();
    waitNeg();
    checkOutput("desync_err_sticky", {31'b0, sync_err}, 32'h1);
    #1 reset = 1'b1;
    #1;
    checkOutput("desync_err_reset", {31'b0, sync_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();

    checkOutput("gnt_scoreboard_drained", expGntQ.size(), 32'd0);
    checkOutput("rd_scoreboard_drained", expRdQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
